// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer feeding the radix-2 streaming FFT core.
// Serial complex samples are loaded into one bank while the other bank is replayed as (x[k], x[k+N/2]) pairs.
module fft_frame_feeder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LOG2N      = 10,
    parameter int unsigned COMPLEX_IN = 0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_re_i,
    input  logic [DATA_W-1:0] s_im_i,
    input  logic              s_last_i,
    input  logic              fft_rdy_i,
    output logic              start_o,
    output logic [DATA_W-1:0] x0_re_o,
    output logic [DATA_W-1:0] x0_im_o,
    output logic [DATA_W-1:0] x1_re_o,
    output logic [DATA_W-1:0] x1_im_o,
    output logic              err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned HW   = LOG2N - 1;
    localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [LOG2N-1:0]   r_wr_idx;
    logic [HW-1:0]      r_k;
    logic [GW-1:0]      r_gap;
    logic               r_ready;
    logic               r_err;
    logic               r_start;
    logic [DATA_W-1:0]  r_x0_re;
    logic [DATA_W-1:0]  r_x0_im;
    logic [DATA_W-1:0]  r_x1_re;
    logic [DATA_W-1:0]  r_x1_im;
    logic [15:0]        r_frame_cnt;

    logic [DATA_W-1:0]  r_mem_lo_re [N];
    logic [DATA_W-1:0]  r_mem_hi_re [N];

    logic               w_accept;
    logic               w_wr_last;
    logic               w_commit;
    logic               w_abort;
    logic               w_err;
    logic               w_wr_bank_nxt;
    logic [1:0]         w_full_wr;
    logic [1:0]         w_full_nxt;
    logic               w_launch_ok;
    logic               w_rd_en;
    logic               w_last_issue;
    logic [LOG2N-1:0]   w_wr_addr;
    logic [LOG2N-1:0]   w_rd_addr;
    logic [DATA_W-1:0]  w_rd_lo_re;
    logic [DATA_W-1:0]  w_rd_hi_re;
    logic [DATA_W-1:0]  w_rd_lo_im;
    logic [DATA_W-1:0]  w_rd_hi_im;

    // Write side: accept, commit on the N-th sample, discard on an early last.
    always_comb begin
        w_accept      = s_valid_i & r_ready;
        w_wr_last     = (r_wr_idx == LOG2N'(N - 1));
        w_commit      = w_accept & w_wr_last;
        w_abort       = w_accept & ~w_wr_last & s_last_i;
        w_err         = (w_commit & ~s_last_i) | w_abort;
        w_wr_bank_nxt = r_wr_bank ^ w_commit;
        w_full_wr     = r_full;
        if (w_commit) begin
            w_full_wr[r_wr_bank] = 1'b1;
        end
        w_full_nxt = w_full_wr;
        if (w_last_issue) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Read FSM next state; the final GAP cycle doubles as the launch decision
    // because start_o trails the issued address by one cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_en      = 1'b0;
        w_last_issue = 1'b0;
        w_launch_ok  = r_full[r_rd_bank] & fft_rdy_i;
        case (r_state)
            S_IDLE: begin
                if (w_launch_ok) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_rd_en = 1'b1;
                if (r_k == HW'(HALF - 1)) begin
                    w_last_issue = 1'b1;
                    w_state_nxt  = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = w_launch_ok ? S_STREAM : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control registers; ready looks only at write-side updates so a freed bank shows up a cycle later.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_full      <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_k         <= '0;
            r_gap       <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_full    <= w_full_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_ready   <= ~w_full_wr[w_wr_bank_nxt];
            r_err     <= w_err;
            if (w_commit || w_abort) begin
                r_wr_idx <= '0;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + LOG2N'(1);
            end
            if (w_rd_en) begin
                r_k <= r_k + HW'(1);
            end
            r_gap <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;
            if (w_last_issue) begin
                r_rd_bank   <= ~r_rd_bank;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign w_wr_addr = {r_wr_bank, r_wr_idx[HW-1:0]};
    assign w_rd_addr = {r_rd_bank, r_k};

    always_ff @(posedge clk) begin
        if (w_accept && !r_wr_idx[LOG2N-1]) begin
            r_mem_lo_re[w_wr_addr] <= s_re_i;
        end
        if (w_accept && r_wr_idx[LOG2N-1]) begin
            r_mem_hi_re[w_wr_addr] <= s_re_i;
        end
    end

    assign w_rd_lo_re = r_mem_lo_re[w_rd_addr];
    assign w_rd_hi_re = r_mem_hi_re[w_rd_addr];

    generate
        if (COMPLEX_IN != 0) begin : g_im
            logic [DATA_W-1:0] r_mem_lo_im [N];
            logic [DATA_W-1:0] r_mem_hi_im [N];

            always_ff @(posedge clk) begin
                if (w_accept && !r_wr_idx[LOG2N-1]) begin
                    r_mem_lo_im[w_wr_addr] <= s_im_i;
                end
                if (w_accept && r_wr_idx[LOG2N-1]) begin
                    r_mem_hi_im[w_wr_addr] <= s_im_i;
                end
            end

            assign w_rd_lo_im = r_mem_lo_im[w_rd_addr];
            assign w_rd_hi_im = r_mem_hi_im[w_rd_addr];
        end else begin : g_no_im
            logic w_im_unused;
            assign w_im_unused = ^s_im_i;
            assign w_rd_lo_im  = '0;
            assign w_rd_hi_im  = '0;
        end
    endgenerate

    // Registered read data; lanes are forced to zero outside a burst.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_start <= 1'b0;
            r_x0_re <= '0;
            r_x0_im <= '0;
            r_x1_re <= '0;
            r_x1_im <= '0;
        end else begin
            r_start <= w_rd_en;
            r_x0_re <= w_rd_en ? w_rd_lo_re : '0;
            r_x0_im <= w_rd_en ? w_rd_lo_im : '0;
            r_x1_re <= w_rd_en ? w_rd_hi_re : '0;
            r_x1_im <= w_rd_en ? w_rd_hi_im : '0;
        end
    end

    assign s_ready_o   = r_ready;
    assign start_o     = r_start;
    assign x0_re_o     = r_x0_re;
    assign x0_im_o     = r_x0_im;
    assign x1_re_o     = r_x1_re;
    assign x1_im_o     = r_x1_im;
    assign err_o       = r_err;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench: a small complex N=8 instance for the directed cases and a default-size
// real instance for the 1024-point ramp.
module tb_fft_frame_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned NS = 8;
    localparam int unsigned HF = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          s_valid, s_ready, s_last, fft_rdy, start, err;
    logic [DW-1:0] s_re, s_im, x0_re, x0_im, x1_re, x1_im;
    logic [15:0]   fcnt;

    logic          b_valid, b_ready, b_last, b_start, b_err;
    logic [31:0]   b_re, b_im, b_x0_re, b_x0_im, b_x1_re, b_x1_im;
    logic [15:0]   b_fcnt;

    fft_frame_feeder #(
        .DATA_W(DW), .LOG2N(3), .COMPLEX_IN(1), .GAP_CYCLES(1)
    ) u_dut (
        .clk(clk), .rstn(rstn), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_re_i(s_re), .s_im_i(s_im), .s_last_i(s_last), .fft_rdy_i(fft_rdy),
        .start_o(start), .x0_re_o(x0_re), .x0_im_o(x0_im), .x1_re_o(x1_re),
        .x1_im_o(x1_im), .err_o(err), .frame_cnt_o(fcnt)
    );

    fft_frame_feeder u_big (
        .clk(clk), .rstn(rstn), .s_valid_i(b_valid), .s_ready_o(b_ready),
        .s_re_i(b_re), .s_im_i(b_im), .s_last_i(b_last), .fft_rdy_i(1'b1),
        .start_o(b_start), .x0_re_o(b_x0_re), .x0_im_o(b_x0_im), .x1_re_o(b_x1_re),
        .x1_im_o(b_x1_im), .err_o(b_err), .frame_cnt_o(b_fcnt)
    );

    typedef struct packed {
        logic [DW-1:0] x0re;
        logic [DW-1:0] x0im;
        logic [DW-1:0] x1re;
        logic [DW-1:0] x1im;
    } pair_t;

    pair_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_frames = 0;
    int    err_cnt  = 0;
    int    last_gap = -1;
    int    big_k    = 0;
    bit    mon_en   = 1'b0;
    bit    abort_burst = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the small instance: pops the scoreboard on every pair.
    int cyc = 0, last_hi = -100, run = 0;
    bit prev_start = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (start) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pair_unexpected: got %0h/%0h with empty scoreboard", x0_re, x1_re);
                end else begin
                    chk("pair", {x0_re, x0_im, x1_re, x1_im}, sb.pop_front());
                end
                if (!prev_start) last_gap = cyc - last_hi - 1;
                last_hi = cyc;
                run++;
            end else begin
                chk("idle_zero", {x0_re, x0_im, x1_re, x1_im}, '0);
                if (prev_start && !abort_burst) chk("burst_len", run, HF);
                run = 0;
            end
            if (err) err_cnt++;
            prev_start = start;
        end
    end

    // Monitor for the default-size instance: pair k must be (k, k+512) with zero imag lanes.
    always @(negedge clk) begin
        if (mon_en && b_start) begin
            chk("big_pair", {b_x0_re, b_x1_re, b_x0_im, b_x1_im},
                {32'(big_k), 32'(big_k + 512), 64'd0});
            big_k++;
        end
    end

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready_o stayed 0, required 1");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // last_pos: index carrying s_last (NS-1 normal, <NS-1 short frame, -1 never asserted).
    task automatic send_frame(input int base, input int last_pos);
        int len = (last_pos >= 0) ? last_pos + 1 : NS;
        if (len == NS) begin
            for (int k = 0; k < HF; k++) begin
                sb.push_back({DW'(base + k), DW'(-(base + k)),
                              DW'(base + k + HF), DW'(-(base + k + HF))});
            end
            exp_frames++;
        end
        for (int i = 0; i < len; i++) begin
            send(DW'(base + i), DW'(-(base + i)), i == last_pos);
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((fcnt != 16'(exp_frames) || start || sb.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: frame_cnt %0d, expected %0d, %0d pairs pending",
                     name, fcnt, exp_frames, sb.size());
        end
        repeat (2) @(negedge clk);
        chk({name, "_frame_cnt"}, fcnt, 16'(exp_frames));
    endtask

    initial begin
        int e0;
        int viol;
        int t;
        rstn = 1'b0; fft_rdy = 1'b1;
        s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0;
        b_valid = 1'b0; b_re = '0; b_im = '0; b_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_frame_cnt", fcnt, 16'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_big_ready", b_ready, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1'b1);

        // Single ramp frame
        send_frame(0, NS - 1);
        wait_done("ramp");

        // Three frames at full input rate
        send_frame(0, NS - 1);
        send_frame(8, NS - 1);
        send_frame(16, NS - 1);
        wait_done("three");

        // Early s_last: one error pulse, frame discarded, next frame clean
        e0 = err_cnt;
        send_frame(100, 4);
        repeat (6) @(negedge clk);
        chk("short_err", err_cnt - e0, 1);
        chk("short_no_frame", fcnt, 16'(exp_frames));
        send_frame(200, NS - 1);
        wait_done("after_short");

        // Missing s_last on the N-th sample: error but committed
        e0 = err_cnt;
        send_frame(300, -1);
        wait_done("no_last");
        chk("no_last_err", err_cnt - e0, 1);

        // Both banks full while the core is not ready
        fft_rdy = 1'b0;
        send_frame(400, NS - 1);
        send_frame(500, NS - 1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_ready || start) viol++;
            @(negedge clk);
        end
        chk("hold_full", viol, 0);
        fft_rdy = 1'b1;
        wait_done("backlog");
        chk("b2b_gap", last_gap, 1);

        // Reset during the second pair of a frame
        send_frame(600, NS - 1);
        t = 0;
        while (!start && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_start_seen", start, 1'b1);
        @(negedge clk);
        abort_burst = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        sb.delete();
        exp_frames = 0;
        chk("mid_rst_start", start, 1'b0);
        chk("mid_rst_frame_cnt", fcnt, 16'd0);
        chk("mid_rst_ready", s_ready, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_ready_back", s_ready, 1'b1);
        abort_burst = 1'b0;
        send_frame(700, NS - 1);
        wait_done("after_rst");

        // Default-size 1024-sample ramp on the real-only instance
        for (int n = 0; n < 1024; n++) begin
            t = 0;
            b_valid = 1'b1;
            b_re    = 32'(n);
            b_im    = 32'hDEAD_0000 | 32'(n);
            b_last  = (n == 1023);
            while (!b_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        t = 0;
        while (b_fcnt != 16'd1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("big_frame_cnt", b_fcnt, 16'd1);
        chk("big_start_cycles", big_k, 512);
        chk("big_no_err", b_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
